conv_out_collector: RTL and testbench

//  Sink-side partner of the 3x3 streaming convolution stage. The conv stage emits one 32-bit result
//  per window position in raster order, including wrap-around positions (cols IMG_W-K+1..IMG_W-1).

---
 rtl/conv_out_collector.sv | 178 +++++++++++++++++
 tb/tb_conv_out_collector.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_out_collector.sv
// conv_out_collector
//   Sink-side partner of the 3x3 streaming convolution stage. The conv stage
//   emits one 32-bit result per window position in raster order, including the
//   wrap-around positions at the right edge of each row. This block throws those
//   away, requantizes the valid results to signed 16-bit (round half up, optional
//   ReLU, saturation) and writes the OUT_W x OUT_H feature map into a
//   single-port RAM starting at BASE_ADDR. done pulses when the map is complete.
//
// Ports
//   clk       in   1    clock
//   rst_n     in   1    synchronous active-low reset
//   start     in   1    begin collecting a frame (only honoured in IDLE)
//   in_data   in   32   signed conv result for the next window position
//   in_valid  in   1    in_data valid this cycle
//   wr_en     out  1    RAM write strobe
//   wr_addr   out  AW   RAM write address
//   wr_data   out  16   signed requantized pixel
//   busy      out  1    high while collecting (RUN)
//   done      out  1    one-cycle pulse when the frame is complete
//   sat_cnt   out  16   saturated samples this frame, sticks at 16'hFFFF

module conv_out_collector #(
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter int K         = 3,
    parameter int SHIFT     = 8,
    parameter int RELU      = 1,
    parameter int AW        = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [31:0]   in_data,
    input  logic          in_valid,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [15:0]   wr_data,
    output logic          busy,
    output logic          done,
    output logic [15:0]   sat_cnt
);

    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST     = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_OUT_LAST = CW'(OUT_W - 1);
    localparam logic [CW-1:0] COL_OUT_END  = CW'(OUT_W);
    localparam logic [RW-1:0] ROW_OUT_LAST = RW'(OUT_H - 1);
    localparam logic [AW-1:0] BASE         = AW'(BASE_ADDR);

    // Rounding constant 1<<(SHIFT-1), written so that SHIFT=0 yields 0
    // without ever forming a negative shift amount.
    localparam logic signed [32:0] RND = (33'sd1 <<< SHIFT) >>> 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [AW-1:0]   wr_ptr;
    logic            accept;
    logic            last_sample;
    logic signed [32:0] sum;
    logic signed [32:0] t;
    logic [15:0]     pix;
    logic            clamp;

    assign accept      = (state_q == S_RUN) && in_valid;
    assign last_sample = accept && (row == ROW_OUT_LAST) && (col == COL_OUT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; busy and done are pure decodes of the state so they
    // line up with the final write without any extra pipelining.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_sample) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Requantization: 33-bit intermediate so the rounding add cannot overflow,
    // arithmetic shift, optional ReLU, then clamp to the signed 16-bit range.
    // A ReLU zeroing is not a saturation event.
    always_comb begin
        sum   = $signed({in_data[31], in_data}) + RND;
        t     = sum >>> SHIFT;
        clamp = 1'b0;
        if ((RELU != 0) && (t < 33'sd0)) begin
            t = 33'sd0;
        end
        pix = t[15:0];
        if (t > 33'sd32767) begin
            pix   = 16'h7FFF;
            clamp = 1'b1;
        end else if (t < -33'sd32768) begin
            pix   = 16'h8000;
            clamp = 1'b1;
        end
    end

    // Position tracking and RAM write port. The write address is an
    // incrementing pointer that only advances on kept samples, which equals
    // BASE + row*OUT_W + col without a multiplier. Wrap-around columns still
    // advance col but produce no write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col     <= '0;
            row     <= '0;
            wr_ptr  <= BASE;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            sat_cnt <= '0;
        end else begin
            wr_en <= 1'b0;
            if ((state_q == S_IDLE) && start) begin
                col     <= '0;
                row     <= '0;
                wr_ptr  <= BASE;
                sat_cnt <= '0;
            end
            if (accept) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                if (col < COL_OUT_END) begin
                    wr_en   <= 1'b1;
                    wr_addr <= wr_ptr;
                    wr_data <= pix;
                    wr_ptr  <= wr_ptr + AW'(1);
                    if (clamp && (sat_cnt != 16'hFFFF)) begin
                        sat_cnt <= sat_cnt + 16'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_out_collector.sv
// tb_conv_out_collector
//   Self-checking bench for conv_out_collector. Two instances share all inputs:
//   "dut" uses RELU=1 (main instance, watched by the write scoreboard) and
//   "dutNr" uses RELU=0 (only checked in the arithmetic table).
//   Expected writes are pushed to a queue as samples are driven and popped by
//   a negedge monitor that also checks the one-cycle write latency.

module tb_conv_out_collector;

    localparam int IMG_W     = 28;
    localparam int OUT_W     = 26;
    localparam int FRAME_LEN = 25 * IMG_W + OUT_W;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic        inValid;
    logic [31:0] inData;

    logic        wrEn, wrEnB;
    logic [9:0]  wrAddr, wrAddrB;
    logic [15:0] wrData, wrDataB;
    logic        busy, busyB;
    logic        done, doneB;
    logic [15:0] satCnt, satCntB;

    int     nChecks = 0;
    int     nBad    = 0;
    longint cyc     = 0;
    bit     sbOn    = 1'b0;

    typedef struct {
        int     addr;
        int     data;
        longint when;
    } wr_t;

    wr_t sbQ[$];

    typedef struct {
        logic [31:0] din;
        int          exp1;
        int          exp0;
        bit          sat1;
        bit          sat0;
    } vec_t;

    vec_t tbl[13];

    conv_out_collector #(.RELU(1)) dut (
        .clk      (clk),
        .rst_n    (rstN),
        .start    (start),
        .in_data  (inData),
        .in_valid (inValid),
        .wr_en    (wrEn),
        .wr_addr  (wrAddr),
        .wr_data  (wrData),
        .busy     (busy),
        .done     (done),
        .sat_cnt  (satCnt)
    );

    conv_out_collector #(.RELU(0)) dutNr (
        .clk      (clk),
        .rst_n    (rstN),
        .start    (start),
        .in_data  (inData),
        .in_valid (inValid),
        .wr_en    (wrEnB),
        .wr_addr  (wrAddrB),
        .wr_data  (wrDataB),
        .busy     (busyB),
        .done     (doneB),
        .sat_cnt  (satCntB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic signed [63:0] act,
                               input logic signed [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nBad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        wr_t e;
        if (sbOn && wrEn === 1'b1) begin
            if (sbQ.size() == 0) begin
                checkOutput("sb unexpected write addr", 64'(wrAddr), -1);
            end else begin
                e = sbQ.pop_front();
                checkOutput("sb addr", 64'(wrAddr), e.addr);
                checkOutput("sb data", 64'($signed(wrData)), e.data);
                checkOutput("sb latency", cyc, e.when);
            end
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sendSample(input logic [31:0] d, input bit expWr, input int addr,
                              input int data, input int gapPct, input bit startToo);
        while ($urandom_range(0, 99) < gapPct) begin
            inValid = 1'b0;
            inData  = $urandom;
            stepCycle();
        end
        inValid = 1'b1;
        inData  = d;
        start   = startToo;
        if (expWr) sbQ.push_back('{addr, data, cyc + 1});
        stepCycle();
        inValid = 1'b0;
        start   = 1'b0;
    endtask

    // Start a frame and stream nSamp samples of p<<8 (requantizes to p).
    task automatic applyStimulus(input int gapPct, input int restartAt,
                                 input bit startWithValid, input int nSamp);
        start   = 1'b1;
        inValid = startWithValid;
        inData  = 32'h0000_5000;
        stepCycle();
        start   = 1'b0;
        inValid = 1'b0;
        checkOutput("busy after start", 64'(busy), 1);
        for (int p = 0; p < nSamp; p++) begin
            int c;
            int r;
            c = p % IMG_W;
            r = p / IMG_W;
            sendSample(32'(p) << 8, c < OUT_W, r * OUT_W + c, p, gapPct, p == restartAt);
        end
        if (nSamp == FRAME_LEN) begin
            @(negedge clk);
            checkOutput("done pulse", 64'(done), 1);
            checkOutput("busy at done", 64'(busy), 0);
            checkOutput("final wr_en", 64'(wrEn), 1);
            checkOutput("final wr_addr", 64'(wrAddr), 675);
            stepCycle();
            @(negedge clk);
            checkOutput("done one cycle", 64'(done), 0);
            checkOutput("sb drained", 64'(sbQ.size()), 0);
            stepCycle();
        end
    endtask

    initial begin
        int s1;
        int s0;
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s1;
        int s0;

        tbl[0]  = '{32'd384,        2,      2,      1'b0, 1'b0};
        tbl[1]  = '{32'd383,        1,      1,      1'b0, 1'b0};
        tbl[2]  = '{32'hFFFF_FE80,  0,     -1,      1'b0, 1'b0};
        tbl[3]  = '{32'h7FFF_FFFF,  32767,  32767,  1'b1, 1'b1};
        tbl[4]  = '{32'h8000_0000,  0,     -32768,  1'b0, 1'b1};
        tbl[5]  = '{32'hFFFF_FF80,  0,      0,      1'b0, 1'b0};
        tbl[6]  = '{32'hFFFF_FF7F,  0,     -1,      1'b0, 1'b0};
        tbl[7]  = '{32'd8388352,    32767,  32767,  1'b0, 1'b0};
        tbl[8]  = '{32'd8388480,    32767,  32767,  1'b1, 1'b1};
        tbl[9]  = '{32'hFF80_0000,  0,     -32768,  1'b0, 1'b0};
        tbl[10] = '{32'hFF7F_FF00,  0,     -32768,  1'b0, 1'b1};
        tbl[11] = '{32'd127,        0,      0,      1'b0, 1'b0};
        tbl[12] = '{32'd128,        1,      1,      1'b0, 1'b0};

        // T1 reset with in_valid high
        rstN    = 1'b0;
        start   = 1'b0;
        inValid = 1'b1;
        inData  = 32'h1234_5678;
        repeat (3) stepCycle();
        @(negedge clk);
        checkOutput("reset wr_en", 64'(wrEn), 0);
        checkOutput("reset busy", 64'(busy), 0);
        checkOutput("reset done", 64'(done), 0);
        checkOutput("reset sat_cnt", 64'(satCnt), 0);
        checkOutput("reset wr_addr", 64'(wrAddr), 0);
        checkOutput("reset relu0 wr_en", 64'(wrEnB), 0);
        rstN    = 1'b1;
        inValid = 1'b0;
        stepCycle();

        // T2 full frame back-to-back
        $display("[TB] full frame");
        sbOn = 1'b1;
        applyStimulus(0, -1, 1'b0, FRAME_LEN);

        // T3 random gaps
        $display("[TB] frame with gaps");
        applyStimulus(40, -1, 1'b0, FRAME_LEN);

        // T4 arithmetic table, both RELU settings
        $display("[TB] arithmetic table");
        sbOn  = 1'b0;
        start = 1'b1;
        stepCycle();
        start = 1'b0;
        s1 = 0;
        s0 = 0;
        for (int i = 0; i < 13; i++) begin
            inData  = tbl[i].din;
            inValid = 1'b1;
            stepCycle();
            inValid = 1'b0;
            s1 += int'(tbl[i].sat1);
            s0 += int'(tbl[i].sat0);
            @(negedge clk);
            checkOutput($sformatf("vec%0d wr_en", i), 64'(wrEn), 1);
            checkOutput($sformatf("vec%0d wr_addr", i), 64'(wrAddr), i);
            checkOutput($sformatf("vec%0d relu1 data", i), 64'($signed(wrData)), tbl[i].exp1);
            checkOutput($sformatf("vec%0d relu0 data", i), 64'($signed(wrDataB)), tbl[i].exp0);
            checkOutput($sformatf("vec%0d relu1 sat_cnt", i), 64'(satCnt), s1);
            checkOutput($sformatf("vec%0d relu0 sat_cnt", i), 64'(satCntB), s0);
            stepCycle();
        end
        rstN = 1'b0;
        stepCycle();
        rstN = 1'b1;
        stepCycle();

        // T5 protocol: restart ignored in RUN, in_valid ignored in IDLE,
        // sample in the start cycle not accepted
        $display("[TB] protocol");
        sbOn = 1'b1;
        applyStimulus(0, 100, 1'b0, FRAME_LEN);
        inValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inData = 32'(i + 5) << 8;
            stepCycle();
            @(negedge clk);
            checkOutput("idle in_valid wr_en", 64'(wrEn), 0);
            checkOutput("idle wr_addr hold", 64'(wrAddr), 675);
        end
        stepCycle();
        inValid = 1'b0;
        applyStimulus(0, -1, 1'b1, FRAME_LEN);

        // T6 reset mid-frame then a fresh frame
        $display("[TB] reset mid-frame");
        applyStimulus(0, -1, 1'b0, 300);
        rstN = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("midreset wr_en", 64'(wrEn), 0);
        checkOutput("midreset busy", 64'(busy), 0);
        checkOutput("midreset done", 64'(done), 0);
        checkOutput("midreset wr_addr", 64'(wrAddr), 0);
        checkOutput("midreset wr_data", 64'(wrData), 0);
        checkOutput("midreset sat_cnt", 64'(satCnt), 0);
        checkOutput("midreset sb drained", 64'(sbQ.size()), 0);
        rstN = 1'b1;
        stepCycle();
        applyStimulus(0, -1, 1'b0, FRAME_LEN);

        sbOn = 1'b0;
        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
